branch_sequencer: RTL

//  Front end of the branch path: owns the architectural PC and the Z/C/N flag register.

---
 rtl/branch_sequencer_if.sv | 47 ++++
 rtl/branch_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// branch_sequencer_if
//   Bundles the instruction handshake, the ALU flag write port and the
//   PC/link outputs of the branch sequencer.
//   master : instruction source / fetch side (drives instr_*, flags)
//   slave  : branch_sequencer (drives instr_ready, pc*, taken, link_*)
// Signals
//   instr_valid  instruction on instr is ready to be resolved
//   instr_ready  sequencer can accept an instruction (IDLE only)
//   instr        [31:26] opcode, [25:0] pseudo-address, [15:0] imm16
//   rs_value     register operand used as the BR target
//   flags_we     write alu_zero/alu_carry/alu_negative into the flag register
//   alu_zero/alu_carry/alu_negative  ALU flags
//   pc           architectural PC (registered)
//   pc_valid     one-cycle pulse when pc has just been updated
//   taken        one-cycle pulse with pc_valid for a redirect
//   link_we      one-cycle pulse with pc_valid for BL
//   link_value   return address (instruction PC + step) while link_we
// ---------------------------------------------------------------------------
interface branch_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs_value;
    logic        flags_we;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_negative;
    logic [31:0] pc;
    logic        pc_valid;
    logic        taken;
    logic        link_we;
    logic [31:0] link_value;

    modport master (
        output instr_valid, instr, rs_value, flags_we,
               alu_zero, alu_carry, alu_negative,
        input  instr_ready, pc, pc_valid, taken, link_we, link_value
    );

    modport slave (
        input  instr_valid, instr, rs_value, flags_we,
               alu_zero, alu_carry, alu_negative,
        output instr_ready, pc, pc_valid, taken, link_we, link_value
    );
endinterface

// File: rtl/branch_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// branch_sequencer
//   Front end of the branch path. Owns the architectural PC and the Z/C/N
//   flag register, accepts one decoded instruction per handshake, resolves
//   its branch class and condition, and commits the next PC for fetch.
//   For BL it also hands the return address to the register file.
//
//   Each instruction walks IDLE -> RESOLVE -> UPDATE: accepted at edge E,
//   PC committed at E+2, next accept possible at E+3.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   branch_sequencer_if.slave (handshake, flags, PC/link outputs)
// Parameters
//   RESET_PC  PC loaded on reset
//   PC_STEP   sequential increment in bytes
// ---------------------------------------------------------------------------
module branch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input logic               clk,
    input logic               rst,
    branch_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESOLVE = 2'd1,
        S_UPDATE  = 2'd2
    } state_e;

    typedef enum logic [5:0] {
        OP_B    = 6'b100000,
        OP_BL   = 6'b100001,
        OP_BR   = 6'b100010,
        OP_BLTZ = 6'b100100,
        OP_BZ   = 6'b100101,
        OP_BNZ  = 6'b100110,
        OP_BCY  = 6'b100111,
        OP_BNCY = 6'b101000
    } opcode_e;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    // FSM
    state_e state_q, state_d;

    // Captured instruction and operand
    logic [31:0] instr_q;
    logic [31:0] rs_q;

    // Flag register
    logic flag_z_q, flag_c_q, flag_n_q;

    // Decision computed in RESOLVE, committed in UPDATE
    logic [31:0] next_pc_q;
    logic        next_taken_q;
    logic        next_link_q;

    // Architectural outputs
    logic [31:0] pc_q;
    logic        pc_valid_q;
    logic        taken_q;
    logic        link_we_q;
    logic [31:0] link_value_q;

    // Combinational resolve results
    logic [5:0]  op;
    logic [31:0] seq_pc;
    logic [31:0] rel_pc;
    logic [31:0] abs_pc;
    logic [31:0] res_pc;
    logic        res_taken;
    logic        res_link;
    logic        is_cond;
    logic        cond_true;

    logic accept;

    assign accept = (state_q == S_IDLE) && bus.instr_valid;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.instr_valid) state_d = S_RESOLVE;
            S_RESOLVE: state_d = S_UPDATE;
            S_UPDATE:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Branch resolution. pc_q still holds the instruction's own PC here, so
    // both sequential and relative targets are based on it.
    // -----------------------------------------------------------------------
    always_comb begin
        op        = instr_q[31:26];
        seq_pc    = pc_q + STEP;
        rel_pc    = pc_q + {{16{instr_q[15]}}, instr_q[15:0]};
        abs_pc    = {pc_q[31:28], instr_q[25:0], 2'b00};
        res_pc    = seq_pc;
        res_taken = 1'b0;
        res_link  = 1'b0;
        is_cond   = 1'b0;
        cond_true = 1'b0;

        case (op)
            OP_B: begin
                res_pc    = abs_pc;
                res_taken = 1'b1;
            end
            OP_BL: begin
                res_pc    = abs_pc;
                res_taken = 1'b1;
                res_link  = 1'b1;
            end
            OP_BR: begin
                res_pc    = rs_q;
                res_taken = 1'b1;
            end
            OP_BLTZ: begin
                is_cond   = 1'b1;
                cond_true = flag_n_q;
            end
            OP_BZ: begin
                is_cond   = 1'b1;
                cond_true = flag_z_q;
            end
            OP_BNZ: begin
                is_cond   = 1'b1;
                cond_true = !flag_z_q;
            end
            OP_BCY: begin
                is_cond   = 1'b1;
                cond_true = flag_c_q;
            end
            OP_BNCY: begin
                is_cond   = 1'b1;
                cond_true = !flag_c_q;
            end
            default: begin
                res_pc    = seq_pc;
                res_taken = 1'b0;
            end
        endcase

        if (is_cond && cond_true) begin
            res_pc    = rel_pc;
            res_taken = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Flag register: written on any edge regardless of FSM state. A write at
    // the accept edge lands before RESOLVE samples it; a write at the end of
    // RESOLVE or later only affects the next instruction.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (bus.flags_we) begin
            flag_z_q <= bus.alu_zero;
            flag_c_q <= bus.alu_carry;
            flag_n_q <= bus.alu_negative;
        end
    end

    // -----------------------------------------------------------------------
    // Instruction capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            rs_q    <= '0;
        end else if (accept) begin
            instr_q <= bus.instr;
            rs_q    <= bus.rs_value;
        end
    end

    // -----------------------------------------------------------------------
    // Decision register, loaded at the edge leaving RESOLVE
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_pc_q    <= RESET_PC;
            next_taken_q <= 1'b0;
            next_link_q  <= 1'b0;
        end else if (state_q == S_RESOLVE) begin
            next_pc_q    <= res_pc;
            next_taken_q <= res_taken;
            next_link_q  <= res_link;
        end
    end

    // -----------------------------------------------------------------------
    // PC commit and output pulses, at the edge leaving UPDATE
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            pc_valid_q   <= 1'b0;
            taken_q      <= 1'b0;
            link_we_q    <= 1'b0;
            link_value_q <= '0;
        end else begin
            pc_valid_q <= 1'b0;
            taken_q    <= 1'b0;
            link_we_q  <= 1'b0;
            if (state_q == S_UPDATE) begin
                pc_q       <= next_pc_q;
                pc_valid_q <= 1'b1;
                taken_q    <= next_taken_q;
                link_we_q  <= next_link_q;
                if (next_link_q) begin
                    link_value_q <= seq_pc;
                end
            end
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.pc          = pc_q;
    assign bus.pc_valid    = pc_valid_q;
    assign bus.taken       = taken_q;
    assign bus.link_we     = link_we_q;
    assign bus.link_value  = link_value_q;

endmodule
